mips_multicycle: RTL

Multicycle successor to the team's single-cycle MIPS core. One finite-state machine sequences each instruction over 3–5 states, and a single unified memory port serves both instruction fetch and data access through a req/ready handshake, so memory wait states stall the core. It implements the same instruction subset as the single-cycle core, plus a halt state for illegal opcodes. It sits between the system memory/bus and the testbench or SoC top.

---
 rtl/mips_multicycle.sv | 341 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS core for the add/sub/and/or/slt, lw/sw,
// beq/bne, addi/ori and j subset. A single FSM steps each instruction through
// 3 to 5 states and shares one memory port between fetch and data access.
// Any illegal opcode or R-type funct parks the core in HALT until reset.
// Optional feature: define MIPS_MC_PERF_EN to add the perf_cycles and
// perf_retired counter outputs.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic        retire
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Sign-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Zero-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] mdr_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] aluout_r;
    logic [31:0] rf_r [0:31];

    logic [5:0]  op_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [5:0]  funct_s;
    logic [31:0] sext_s;
    logic [31:0] zext_s;
    logic [31:0] rf_rs_s;
    logic [31:0] rf_rt_s;
    logic        funct_legal_s;
    logic [31:0] alu_result_s;
    logic        branch_take_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] rf_wdata_s;

    assign op_s    = ir_r[31:26];
    assign rs_s    = ir_r[25:21];
    assign rt_s    = ir_r[20:16];
    assign rd_s    = ir_r[15:11];
    assign funct_s = ir_r[5:0];
    assign sext_s  = sext16(ir_r[15:0]);
    assign zext_s  = zext16(ir_r[15:0]);

    // $0 always reads as zero; the array entry itself is never written.
    assign rf_rs_s = (rs_s == 5'd0) ? 32'd0 : rf_r[rs_s];
    assign rf_rt_s = (rt_s == 5'd0) ? 32'd0 : rf_r[rt_s];

    // R-type funct legality and ALU operation for the EXEC state.
    always_comb begin
        funct_legal_s = 1'b1;
        alu_result_s  = 32'd0;
        case (funct_s)
            FN_ADD:  alu_result_s = a_r + b_r;
            FN_SUB:  alu_result_s = a_r - b_r;
            FN_AND:  alu_result_s = a_r & b_r;
            FN_OR:   alu_result_s = a_r | b_r;
            FN_SLT:  alu_result_s = {31'd0, ($signed(a_r) < $signed(b_r))};
            default: begin
                funct_legal_s = 1'b0;
                alu_result_s  = 32'd0;
            end
        endcase
    end

    // Branch condition: equality for beq, inequality for bne.
    always_comb begin
        if (op_s == OP_BNE) begin
            branch_take_s = (a_r != b_r);
        end else begin
            branch_take_s = (a_r == b_r);
        end
    end

    // Register-file write port: source and destination depend on the write-back state.
    always_comb begin
        rf_we_s    = 1'b0;
        rf_waddr_s = rt_s;
        rf_wdata_s = aluout_r;
        if (reset) begin
            rf_we_s = 1'b0;
        end else begin
            case (state_r)
                S_MEMWB: begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rt_s;
                    rf_wdata_s = mdr_r;
                end
                S_ALUWB: begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rd_s;
                    rf_wdata_s = aluout_r;
                end
                S_IWB: begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rt_s;
                    rf_wdata_s = aluout_r;
                end
                default: rf_we_s = 1'b0;
            endcase
        end
    end

    // Register file storage; not reset, writes to $0 are dropped.
    always_ff @(posedge clk) begin
        if (rf_we_s && (rf_waddr_s != 5'd0)) begin
            rf_r[rf_waddr_s] <= rf_wdata_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; memory states wait for mem_ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op_s)
                    OP_RTYPE: begin
                        if (funct_legal_s) begin
                            state_nxt_s = S_EXEC;
                        end else begin
                            state_nxt_s = S_HALT;
                        end
                    end
                    OP_LW, OP_SW:    state_nxt_s = S_MEMADR;
                    OP_BEQ, OP_BNE:  state_nxt_s = S_BRANCH;
                    OP_ADDI, OP_ORI: state_nxt_s = S_IEXEC;
                    OP_J:            state_nxt_s = S_JUMP;
                    default:         state_nxt_s = S_HALT;
                endcase
            end
            S_MEMADR: begin
                if (op_s == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_MEMWB:  state_nxt_s = S_FETCH;
            S_EXEC:   state_nxt_s = S_ALUWB;
            S_ALUWB:  state_nxt_s = S_FETCH;
            S_IEXEC:  state_nxt_s = S_IWB;
            S_IWB:    state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            S_JUMP:   state_nxt_s = S_FETCH;
            S_HALT:   state_nxt_s = S_HALT;
            default:  state_nxt_s = S_HALT;
        endcase
    end

    // FSM outputs: memory port, halted and retire decoded from state, forced quiet in reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_r;
        mem_wdata = 32'd0;
        halted    = 1'b0;
        retire    = 1'b0;
        if (reset) begin
            mem_addr = RESET_PC;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_r;
                end
                S_MEMRD: begin
                    mem_req  = 1'b1;
                    mem_addr = aluout_r;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = aluout_r;
                    mem_wdata = b_r;
                    retire    = mem_ready;
                end
                S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
                S_HALT:  halted = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    // Datapath registers: PC, IR, MDR, A, B and ALUOut updated per state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            ir_r     <= 32'd0;
            mdr_r    <= 32'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            aluout_r <= 32'd0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_r <= mem_rdata;
                        pc_r <= pc_r + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_r      <= rf_rs_s;
                    b_r      <= rf_rt_s;
                    aluout_r <= pc_r + {sext_s[29:0], 2'b00};
                end
                S_MEMADR: aluout_r <= a_r + sext_s;
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr_r <= mem_rdata;
                    end
                end
                S_EXEC: aluout_r <= alu_result_s;
                S_IEXEC: begin
                    if (op_s == OP_ORI) begin
                        aluout_r <= a_r | zext_s;
                    end else begin
                        aluout_r <= a_r + sext_s;
                    end
                end
                S_BRANCH: begin
                    if (branch_take_s) begin
                        pc_r <= aluout_r;
                    end
                end
                S_JUMP: pc_r <= {pc_r[31:28], ir_r[25:0], 2'b00};
                default: pc_r <= pc_r;
            endcase
        end
    end

`ifdef MIPS_MC_PERF_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_retired_r;

    // Performance counters: active cycles (HALT excluded) and retired instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_r  <= 32'd0;
            perf_retired_r <= 32'd0;
        end else begin
            if (state_r != S_HALT) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end
            if (retire) begin
                perf_retired_r <= perf_retired_r + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_r;
    assign perf_retired = perf_retired_r;
`endif

endmodule
